// File: rtl/mem_port_arbiter_if.sv
// Request/ack and memory-port signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the two requesters plus the memory (the side that owns everything the
// arbiter reads).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // port 0: instruction fetch
    logic          req0;
    logic [AW-1:0] addr0;
    logic          we0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;
    // port 1: data load/store
    logic          req1;
    logic [AW-1:0] addr1;
    logic          we1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;
    // shared memory port
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    // status
    logic          busy;
    logic          gnt_id;

    modport slave (
        input  req0, addr0, we0, wdata0,
        input  req1, addr1, we1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_addr, mem_we, mem_wdata,
        output busy, gnt_id
    );

    modport master (
        output req0, addr0, we0, wdata0,
        output req1, addr1, we1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_addr, mem_we, mem_wdata,
        input  busy, gnt_id
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the fetch
// port (0) and the load/store port (1). Sequence per access:
// IDLE (arbitrate, latch) -> ISSUE (mem_we strobe) -> WAIT (MEM_LAT cycles,
// capture read data) -> RESP (one-cycle ack to the winner).
// Optional build macro MEM_ARB_ROUND_ROBIN_EN replaces the fixed
// "port 1 wins" priority with a 1-bit round-robin pointer.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1    // 1..7
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          gnt_id_q, gnt_id_d;
    logic          win;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          rr_ptr_q, rr_ptr_d;
`endif

    // Winner selection: a lone requester always wins; contention is broken
    // by fixed priority (port 1) or by the round-robin pointer.
    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = (bus.req0 && bus.req1) ? rr_ptr_q : bus.req1;
`else
        win = bus.req1;
`endif
    end

    // Next-state, address/data latching, latency count and read capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        gnt_id_d    = gnt_id_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_id_d    = win;
                    mem_addr_d  = win ? bus.addr1  : bus.addr0;
                    mem_we_d    = win ? bus.we1    : bus.we0;
                    mem_wdata_d = win ? bus.wdata1 : bus.wdata0;
                    cnt_d       = 3'(MEM_LAT);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    rr_ptr_d    = ~win;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // memory samples address/strobe this cycle; strobe is one cycle wide
                mem_we_d = 1'b0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    // capture happens for writes too; the value is simply unused
                    if (gnt_id_q) rdata1_d = bus.mem_rdata;
                    else          rdata0_d = bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            gnt_id_q    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            gnt_id_q    <= gnt_id_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ack0      = (state_q == RESP) && !gnt_id_q;
    assign bus.ack1      = (state_q == RESP) &&  gnt_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: MEM_LAT=1 instance driven by queued
// requesters and checked against a transaction-level model, plus a
// MEM_LAT=3 instance for the latency case.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int LATB = 3;

    typedef struct {
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) busb ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT))  dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LATB)) dutb (.clk(clk), .reset(reset), .bus(busb.slave));

    // ---------------- memory models ----------------
    logic          ld_en;
    logic [7:0]    ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] pipe_a [LAT];
    logic [DW-1:0] pipe_b [LATB];

    always @(posedge clk) begin
        pipe_a[0] <= mem_a[bus.mem_addr[7:0]];
        for (int k = 1; k < LAT; k++) pipe_a[k] <= pipe_a[k-1];
        if (ld_en) mem_a[ld_addr] <= ld_data;
        else if (bus.mem_we) mem_a[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    always @(posedge clk) begin
        pipe_b[0] <= mem_b[busb.mem_addr[7:0]];
        for (int k = 1; k < LATB; k++) pipe_b[k] <= pipe_b[k-1];
        if (ld_en) mem_b[ld_addr] <= ld_data;
        else if (busb.mem_we) mem_b[busb.mem_addr[7:0]] <= busb.mem_wdata;
    end
    assign bus.mem_rdata  = pipe_a[LAT-1];
    assign busb.mem_rdata = pipe_b[LATB-1];

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [256];
    item_t         q0[$], q1[$];
    item_t         cur [2];
    bit [1:0]      pend;
    int            cyc, free_c, g_cyc, exp_port;
    item_t         g_item;
    logic [DW-1:0] g_rd;
    bit            rr;
    logic [DW-1:0] exp_rd [2];
    bit [1:0]      rd_known;
    int            acks0[$], acks1[$];
    logic [DW-1:0] ack_rd0, ack_rd1;
    int            we_cnt;
    int            errors = 0;
    int            checks = 0;

    function automatic logic [DW-1:0] hval(int a);
        return (32'h9E3779B9 * 32'(a + 1)) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        pend = 2'b00; free_c = 0; g_cyc = -100; exp_port = 0; rr = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0; rd_known = 2'b11;
        acks0.delete(); acks1.delete();
    endtask

    // One clock cycle: requesters present queued work, the model arbitrates
    // from the request rules, outputs are compared mid-cycle.
    task automatic run_cycle();
        int  w;
        bit  in_txn, is_ack;
        if (!pend[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); pend[0] = 1'b1; end
        if (!pend[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); pend[1] = 1'b1; end
        bus.req0 = pend[0]; bus.addr0 = cur[0].a; bus.we0 = cur[0].w; bus.wdata0 = cur[0].d;
        bus.req1 = pend[1]; bus.addr1 = cur[1].a; bus.we1 = cur[1].w; bus.wdata1 = cur[1].d;
        if (cyc >= free_c && pend != 2'b00) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = (pend == 2'b11) ? int'(rr) : (pend[1] ? 1 : 0);
`else
            w = pend[1] ? 1 : 0;
`endif
            rr       = (w == 0);
            exp_port = w;
            g_cyc    = cyc;
            g_item   = cur[w];
            free_c   = cyc + 3 + LAT;
            g_rd     = ref_mem[g_item.a[7:0]];
            if (g_item.w) ref_mem[g_item.a[7:0]] = g_item.d;
        end
        @(negedge clk);
        in_txn = (cyc > g_cyc) && (cyc <= g_cyc + 2 + LAT);
        is_ack = (cyc == g_cyc + 2 + LAT);
        chk("busy", bus.busy, in_txn);
        chk("mem_we", bus.mem_we, (cyc == g_cyc + 1) && g_item.w);
        if (cyc == g_cyc + 1) begin
            chk("mem_addr", bus.mem_addr, g_item.a);
            if (g_item.w) chk("mem_wdata", bus.mem_wdata, g_item.d);
        end
        if (in_txn) chk("gnt_id", bus.gnt_id, exp_port[0]);
        chk("ack0", bus.ack0, is_ack && exp_port == 0);
        chk("ack1", bus.ack1, is_ack && exp_port == 1);
        if (is_ack) begin
            exp_rd[exp_port]   = g_rd;
            rd_known[exp_port] = !g_item.w;
            pend[exp_port]     = 1'b0;
        end
        if (rd_known[0]) chk("rdata0", bus.rdata0, exp_rd[0]);
        if (rd_known[1]) chk("rdata1", bus.rdata1, exp_rd[1]);
        if (bus.mem_we) we_cnt++;
        if (bus.ack0) begin acks0.push_back(cyc); ack_rd0 = bus.rdata0; end
        if (bus.ack1) begin acks1.push_back(cyc); ack_rd1 = bus.rdata1; end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_n(int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    function automatic item_t mk(logic [AW-1:0] a, logic w, logic [DW-1:0] d);
        item_t it;
        it.a = a; it.w = w; it.d = d;
        return it;
    endfunction

    initial begin
        int t0, snap, guard;
        item_t it;
        reset = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        cur[0] = mk('0, 1'b0, '0); cur[1] = mk('0, 1'b0, '0);
        g_item = mk('0, 1'b0, '0); g_rd = '0; ack_rd0 = '0; ack_rd1 = '0;
        bus.req0 = 0; bus.addr0 = '0; bus.we0 = 0; bus.wdata0 = '0;
        bus.req1 = 0; bus.addr1 = '0; bus.we1 = 0; bus.wdata1 = '0;
        busb.req0 = 0; busb.addr0 = '0; busb.we0 = 0; busb.wdata0 = '0;
        busb.req1 = 0; busb.addr1 = '0; busb.we1 = 0; busb.wdata1 = '0;
        we_cnt = 0; cyc = 0;
        model_reset();

        // preload both memories while the arbiters sit in reset
        for (int i = 0; i < 256; i++) ref_mem[i] = hval(i);
        ref_mem[8'h10] = 32'hDEADBEEF;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = ref_mem[i];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);     chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);     chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_gnt", bus.gnt_id, 0);    chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata0", bus.rdata0, 0); chk("rst_rdata1", bus.rdata1, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        cyc = 0;

        // contention (pointer starts at 0 after reset); port 0 re-requests
        // right after its first ack to create a second contention
        t0 = cyc;
        q0.push_back(mk(32'h40, 1'b0, '0));
        q0.push_back(mk(32'h44, 1'b0, '0));
        q1.push_back(mk(32'h48, 1'b0, '0));
        run_n(13);
        chk("cont_n0", acks0.size(), 2);
        chk("cont_n1", acks1.size(), 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("cont_ack0_a", acks0[0] - t0, 3);
        chk("cont_ack1", acks1[0] - t0, 7);
`else
        chk("cont_ack1", acks1[0] - t0, 3);
        chk("cont_ack0_a", acks0[0] - t0, 7);
`endif
        chk("cont_ack0_b", acks0[1] - t0, 11);

        // single fetch
        acks0.delete(); acks1.delete();
        t0 = cyc;
        q0.push_back(mk(32'h10, 1'b0, '0));
        run_n(5);
        chk("fetch_n", acks0.size(), 1);
        chk("fetch_lat", acks0[0] - t0, 3);
        chk("fetch_data", ack_rd0, 32'hDEADBEEF);
        chk("fetch_no_ack1", acks1.size(), 0);

        // data write then fetch read-back
        acks0.delete(); acks1.delete();
        snap = we_cnt;
        t0 = cyc;
        q1.push_back(mk(32'h20, 1'b1, 32'h12345678));
        run_n(4);
        q0.push_back(mk(32'h20, 1'b0, '0));
        run_n(5);
        chk("wr_we_cycles", we_cnt - snap, 1);
        chk("wr_ack1", acks1[0] - t0, 3);
        chk("rb_ack0", acks0[0] - t0, 7);
        chk("rb_data", ack_rd0, 32'h12345678);

        // back-to-back on port 0, req held, address changes after first ack
        acks0.delete(); acks1.delete();
        t0 = cyc;
        q0.push_back(mk(32'h10, 1'b0, '0));
        q0.push_back(mk(32'h24, 1'b0, '0));
        run_n(9);
        chk("b2b_n", acks0.size(), 2);
        chk("b2b_first", acks0[0] - t0, 3);
        chk("b2b_second", acks0[1] - t0, 7);
        chk("b2b_data", ack_rd0, hval(32'h24));

        // MEM_LAT=3 instance: single read on port 0
        busb.req0 = 1'b1; busb.addr0 = 32'h33; busb.we0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("lat3_ack0", busb.ack0, k == 5);
            chk("lat3_ack1", busb.ack1, 0);
            chk("lat3_busy", busb.busy, (k >= 1) && (k <= 5));
            if (k == 5) chk("lat3_data", busb.rdata0, hval(32'h33));
            @(posedge clk); #1;
            cyc++;
            if (busb.ack0 || k == 5) busb.req0 = 1'b0;
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && !pend[0] && $urandom_range(0, 2) == 0)
                q0.push_back(mk(32'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0), $urandom));
            if (q1.size() == 0 && !pend[1] && $urandom_range(0, 2) == 0)
                q1.push_back(mk(32'($urandom_range(0, 63)), ($urandom_range(0, 2) == 0), $urandom));
            run_cycle();
        end
        guard = 0;
        while ((pend != 2'b00 || q0.size() > 0 || q1.size() > 0 || cyc < free_c) && guard < 60) begin
            run_cycle();
            guard++;
        end
        chk("drain_timeout", guard >= 60, 0);

        // reset during WAIT of a port-1 read
        acks0.delete(); acks1.delete();
        q1.push_back(mk(32'h05, 1'b0, '0));
        run_n(2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_busy", bus.busy, 0);   chk("mid_mem_we", bus.mem_we, 0);
        chk("mid_ack1", bus.ack1, 0);   chk("mid_rdata1", bus.rdata1, 0);
        chk("mid_rdata0", bus.rdata0, 0);
        model_reset();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        cyc++;
        run_n(6);
        chk("post_rst_no_ack1", acks1.size(), 0);
        t0 = cyc;
        q0.push_back(mk(32'h08, 1'b0, '0));
        run_n(5);
        chk("post_rst_n0", acks0.size(), 1);
        chk("post_rst_lat", acks0[0] - t0, 3);
        chk("post_rst_data", ack_rd0, ref_mem[8'h08]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between two requesters: port 0 is instruction fetch (PC/ADDR path) and port 1 is data load/store (G-addressed access).
- Arbitrates between the two ports, sequences the memory wait cycle(s), captures read data and returns a one-cycle ack to the winning requester.
- Sits between the proc control FSM and the memory.
- Replaces the fixed fetch → mem_wait → decode timing assumption with an explicit req/ack handshake.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from the edge that samples mem_addr to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  fetch request; held with addr0/we0/wdata0 stable until ack0.
- addr0  in  AW  fetch address.
- we0  in  1  fetch write enable (normally 0).
- wdata0  in  DW  fetch write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DW  read data for port 0; valid while ack0=1.
- req1, addr1, we1, wdata1, ack1, rdata1: same as port 0, for the data port.
- mem_addr  out  AW  registered memory address.
- mem_we  out  1  registered memory write strobe.
- mem_wdata  out  DW  registered memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  1  port currently or last served.

Behaviour:
- Reset is asynchronous, active-high, applied from any state:
  - State returns to IDLE; latency counter cleared.
  - ack0, ack1, mem_we, busy, gnt_id, rr_ptr all 0.
  - mem_addr, mem_wdata, rdata0, rdata1 all 0.
  - An in-flight access is abandoned and no ack is ever issued for it. A write already strobed may have landed in memory.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither req0 nor req1 is high, stay in IDLE.
  - Otherwise pick a winner. Default is fixed priority: port 1 beats port 0.
  - At the clock edge, latch the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, set gnt_id, load cnt=MEM_LAT, and go to ISSUE.
- ISSUE (1 cycle):
  - Memory samples mem_addr and mem_we this cycle.
  - At the edge, clear mem_we (it is high for exactly one cycle) and go to WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt reaches 1, capture mem_rdata into rdata[gnt_id] at the edge and go to RESP.
  - With MEM_LAT=1, WAIT lasts exactly 1 cycle.
- RESP (1 cycle): assert ack[gnt_id]=1, then go to IDLE.
- Latency: a request seen in IDLE in cycle N produces an ack in cycle N+2+MEM_LAT (cycle 3 for MEM_LAT=1). Writes take the same latency as reads. For a write, rdata is don't-care but still gets captured.
- Handshake rules:
  - A requester drops req in the cycle after ack. A req still high in IDLE is treated as a new request.
  - Inputs of the losing port are ignored. Its req is not latched and must stay high until it is served.
- Simultaneous req0 and req1 in IDLE: port 1 wins. Port 0 is served next, in the IDLE cycle that follows RESP.
- The memory port is idle for at least 1 cycle (the IDLE cycle) between transactions.
- rdataX holds its last captured value until the next capture for that port.
- ack0 and ack1 are never high together.
- Address/data widths are passed straight through. There is no alignment check and no address arithmetic.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit rr_ptr register, reset to 0, names the preferred port.
  - On contention the port equal to rr_ptr wins.
  - On each grant, rr_ptr is set to the port that did not win.
  - A single requester always wins regardless of rr_ptr.
- Not defined: fixed priority, port 1 over port 0. rr_ptr does not exist.

Test Plan:
- Single fetch:
  - Stimulus: memory preloaded [0x10]=0xDEADBEEF; req0=1, addr0=0x10, we0=0 in cycle 0; MEM_LAT=1.
  - Required response: mem_addr=0x10 in cycle 1; ack0=1 and rdata0=0xDEADBEEF in cycle 3; busy in cycles 1-3; ack1 never high.
- Data write then fetch read-back:
  - Stimulus: req1 with addr1=0x20, we1=1, wdata1=0x12345678, held until ack1; then req0 with addr0=0x20.
  - Required response: mem_we=1 for exactly one cycle; ack1 in cycle 3; ack0 in cycle 7 with rdata0=0x12345678.
- Contention:
  - Stimulus: req0 and req1 both high in cycle 0, each held until its ack.
  - Required response without macro: ack1 in cycle 3, ack0 in cycle 7.
  - Required response with MEM_ARB_ROUND_ROBIN_EN: ack0 in cycle 3, ack1 in cycle 7. A following contention gives port 1 first.
- Latency parameter:
  - Stimulus: MEM_LAT=3, single read on port 0.
  - Required response: ack0 in cycle 5; rdata0 equals the memory content at addr0.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously during WAIT of a port-1 read.
  - Required response: immediately busy=0, mem_we=0, ack1=0, rdata1=0; no ack follows after reset release. A req0 issued after release completes normally 3 cycles later.
- Back-to-back on one port:
  - Stimulus: req0 held high continuously for two fetches, with addr0 changed right after the first ack0.
  - Required response: two ack0 pulses 4 cycles apart (cycles 3 and 7); the second rdata0 matches the new address.
